ads1292_filter_chmux: RTL and testbench
=======================================

Name: ads1292_filter_chmux

Overview:
- Time-multiplexes NUM_CH independent stb/ack sample streams (one per ECG/RESP channel) onto one shared ads1292_filter instance.
- Routes each filtered result back to its originating channel.
- Sits between per-channel sources (ADS1292 deframer or file_reader) and per-channel sinks (file_writer or downstream logic).
- Generalises the single-channel source -> filter -> sink chain to N channels, with fair arbitration and in-flight tag tracking.

Parameters:
- DATA_W, 32, sample width in bits, both directions.
- NUM_CH, 2, number of channels; legal range 2..8.
- TAG_DEPTH, 4, maximum samples in flight inside the filter; power of two, 2..16.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- input_a  in  NUM_CH*DATA_W  per-channel samples; channel k occupies bits [k*DATA_W +: DATA_W].
- input_a_stb  in  NUM_CH  per-channel sample valid.
- input_a_ack  out  NUM_CH  per-channel accept; one-cycle pulse.
- filt_in_z  out  DATA_W  sample to the filter.
- filt_in_stb  out  1  sample valid to the filter.
- filt_in_ack  in  1  filter accept.
- filt_out_a  in  DATA_W  filtered result from the filter.
- filt_out_stb  in  1  result valid from the filter.
- filt_out_ack  out  1  result accept; one-cycle pulse.
- output_z  out  DATA_W  routed result (shared bus).
- output_z_stb  out  NUM_CH  one-hot result valid, per channel.
- output_z_ack  in  NUM_CH  per-channel sink accept.
- inflight  out  $clog2(TAG_DEPTH+1)  tag FIFO occupancy.

Behaviour:
- Handshake rule, all interfaces: a transfer occurs on a cycle where stb=1 and ack=1.
  - A producer holds stb and data stable until that cycle, then drops stb the next cycle.
  - Acks from this block are single-cycle pulses.
- Reset, synchronous, priority over everything:
  - All acks = 0, all stbs = 0, filt_in_z = 0, output_z = 0.
  - Round-robin pointer = 0, tag FIFO emptied, inflight = 0.
  - Issue FSM returns to ARB. In-flight samples are discarded.
  - Reset held mid-transfer aborts that transfer; no ack is issued during rst.
- Issue FSM, states ARB and SEND:
  - ARB: if the tag FIFO is not full and some input_a_stb[k]=1, pick the first requesting k, searching upward from the pointer with wrap NUM_CH-1 -> 0.
  - On that pick: latch input_a[k] into filt_in_z, push tag k, pulse input_a_ack[k] for 1 cycle, set pointer = (k+1) mod NUM_CH, go to SEND.
  - ARB with the FIFO full, or no requests: stay in ARB, no ack.
  - SEND: filt_in_stb=1. When filt_in_ack=1, drop filt_in_stb the next cycle and go to ARB.
  - Latency: input accept cycle T -> filt_in_stb high at T+1.
  - Maximum issue rate: one sample per 2 cycles, plus filter ack delay.
- Fairness: with all channels continuously requesting, grants go 0,1,...,NUM_CH-1,0,... Each channel is starved for at most NUM_CH-1 grants.
- Return path (single output register, states EMPTY and FULL):
  - EMPTY: if filt_out_stb=1 and the FIFO is not empty, pulse filt_out_ack, capture filt_out_a into output_z, pop tag t, assert output_z_stb[t], go to FULL.
  - filt_out_stb=1 with the FIFO empty: protocol error; filt_out_ack stays 0 (stall) and no output is produced.
  - FULL: hold output_z and output_z_stb. When output_z_ack[t]=1, clear stb the next cycle and go to EMPTY. Acks on other channels are ignored.
  - Latency: filt_out_ack cycle T -> output_z_stb at T+1.
- The filter must return exactly one result per input, in order; tags are matched FIFO order.
- Tag FIFO:
  - Push occurs in ARB on a grant; pop occurs in the return path on capture.
  - Simultaneous push and pop are legal at any occupancy; when FULL, push is already blocked by the ARB full check.
  - inflight counts up/down, wraps never, and remains in 0..TAG_DEPTH.
- A blocked sink on channel t stalls the whole return path. This is head-of-line blocking by design, and back-pressures the filter.

Decomposition:
- Package ads1292_pkg: DATA_W default, MAX_CH, issue-state enum {ARB,SEND}, return-state enum {EMPTY,FULL}, tag width function $clog2(NUM_CH).
- One sub-module: chmux_tag_fifo.
  - Synchronous FIFO, width = tag width, depth = TAG_DEPTH.
  - Ports: push, pop, din, dout, full, empty, count.
  - Registered pointers with wrap at TAG_DEPTH.

Test Plan:
- Reset and idle: rst high for 3 cycles, then idle -> all stb/ack 0, inflight=0, output_z=0.
- Single channel with an echo filter model (ack 1 cycle after stb, result = input+1): ch1 sends 0x00000010 -> filt_in_z=0x10 at T+1; output_z=0x11 with output_z_stb=2'b10.
- Fairness: NUM_CH=4, all channels streaming continuously, ch k sends k*0x100+n -> filter sees the tag order 0,1,2,3,0,1,... and each output_z_stb[k] delivers values in per-channel order n=0..7.
- Full FIFO: TAG_DEPTH=4, filter holds filt_out_stb=0 -> exactly 4 input acks, inflight=4, no 5th ack. Release the filter -> all 4 results routed correctly, inflight returns to 0.
- Sink back-pressure: ch0 output_z_ack held low for 10 cycles -> output_z_stb[0] and output_z stay stable, filt_out_ack stays 0, with no data loss.
- Mid-operation reset: rst asserted during SEND with inflight=3 -> the next cycle has inflight=0 and filt_in_stb=0. Spurious filt_out_stb afterwards is not acked.

Source files
------------

// File: rtl/ads1292_pkg.sv
// Shared definitions for the ADS1292 filter channel multiplexer.
//   DATA_W_DEF : default sample width
//   MAX_CH     : largest supported channel count
//   issue_state_t / ret_state_t : issue and return FSM encodings
//   tag_w()    : width of a channel tag for a given channel count
package ads1292_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int MAX_CH     = 8;

    typedef enum logic {
        ARB,
        SEND
    } issue_state_t;

    typedef enum logic {
        EMPTY,
        FULL
    } ret_state_t;

    function automatic int tag_w(input int num_ch);
        return (num_ch < 2) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/chmux_tag_fifo.sv
// Small synchronous FIFO holding the channel tag of every sample in flight
// inside the shared filter.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : write a tag (ignored when full)
//   pop/dout : dout is the head tag; pop advances past it (ignored when empty)
//   full, empty, count : occupancy flags and count (0..DEPTH)
module chmux_tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // The head tag must be visible in the same cycle it is popped, so the
    // storage is read without a register stage.
    assign dout = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ads1292_filter_chmux.sv
// Time-multiplexes NUM_CH stb/ack sample streams onto one shared filter and
// routes each filtered result back to the channel it came from.
//   clk, rst            : clock, synchronous active-high reset
//   input_a[_stb/_ack]  : per-channel sample inputs (channel k at [k*DATA_W +: DATA_W])
//   filt_in_z[_stb/_ack]: sample stream towards the filter
//   filt_out_a[_stb/_ack]: result stream from the filter
//   output_z, output_z_stb/_ack : shared result bus with one-hot per-channel valid
//   inflight            : number of samples currently inside the filter
module ads1292_filter_chmux
    import ads1292_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int NUM_CH    = 2,
    parameter int TAG_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH*DATA_W-1:0]       input_a,
    input  logic [NUM_CH-1:0]              input_a_stb,
    output logic [NUM_CH-1:0]              input_a_ack,
    output logic [DATA_W-1:0]              filt_in_z,
    output logic                           filt_in_stb,
    input  logic                           filt_in_ack,
    input  logic [DATA_W-1:0]              filt_out_a,
    input  logic                           filt_out_stb,
    output logic                           filt_out_ack,
    output logic [DATA_W-1:0]              output_z,
    output logic [NUM_CH-1:0]              output_z_stb,
    input  logic [NUM_CH-1:0]              output_z_ack,
    output logic [$clog2(TAG_DEPTH+1)-1:0] inflight
);

    localparam int TAG_W = tag_w(NUM_CH);

    issue_state_t      issue_state_reg, issue_state_next;
    ret_state_t        ret_state_reg, ret_state_next;
    logic [TAG_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [DATA_W-1:0] filt_in_z_reg, filt_in_z_next;
    logic [DATA_W-1:0] output_z_reg, output_z_next;
    logic [TAG_W-1:0]  out_tag_reg, out_tag_next;

    logic [TAG_W-1:0]  ch_dist [NUM_CH];
    logic [TAG_W-1:0]  best_dist;
    logic              grant_valid;
    logic [TAG_W-1:0]  grant_idx;
    logic [DATA_W-1:0] grant_data;
    logic              issue_fire;
    logic              capture;
    logic [NUM_CH-1:0] sink_ack_vec;
    logic              sink_ack;

    logic [TAG_W-1:0]  fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;

    // Distance of each channel from the round-robin pointer, going upward
    // with wrap; the requester with the smallest distance wins.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_dist
        localparam logic [TAG_W:0] CH_ID  = (TAG_W+1)'(gi);
        localparam logic [TAG_W:0] CH_NUM = (TAG_W+1)'(NUM_CH);
        logic [TAG_W:0] ptr_ext;
        logic [TAG_W:0] dist_ext;
        assign ptr_ext  = {1'b0, rr_ptr_reg};
        assign dist_ext = (CH_ID >= ptr_ext) ? (CH_ID - ptr_ext)
                                             : (CH_ID + CH_NUM - ptr_ext);
        assign ch_dist[gi] = dist_ext[TAG_W-1:0];
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        best_dist   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (input_a_stb[i] && (!grant_valid || (ch_dist[i] < best_dist))) begin
                grant_valid = 1'b1;
                grant_idx   = TAG_W'(i);
                best_dist   = ch_dist[i];
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_idx == TAG_W'(i)) begin
                grant_data = input_a[i*DATA_W +: DATA_W];
            end
        end
    end

    // Handshake qualifiers; reset suppresses every ack combinationally.
    assign issue_fire = (issue_state_reg == ARB) && grant_valid && !fifo_full && !rst;
    assign capture    = (ret_state_reg == EMPTY) && filt_out_stb && !fifo_empty && !rst;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        assign input_a_ack[gi]  = issue_fire && (grant_idx == TAG_W'(gi));
        assign output_z_stb[gi] = (ret_state_reg == FULL) && (out_tag_reg == TAG_W'(gi)) && !rst;
        // Only the channel currently holding the result can release it.
        assign sink_ack_vec[gi] = output_z_stb[gi] && output_z_ack[gi];
    end

    assign sink_ack     = |sink_ack_vec;
    assign filt_in_stb  = (issue_state_reg == SEND) && !rst;
    assign filt_in_z    = filt_in_z_reg;
    assign filt_out_ack = capture;
    assign output_z     = output_z_reg;

    always_comb begin
        issue_state_next = issue_state_reg;
        rr_ptr_next      = rr_ptr_reg;
        filt_in_z_next   = filt_in_z_reg;
        case (issue_state_reg)
            ARB: begin
                if (issue_fire) begin
                    filt_in_z_next   = grant_data;
                    rr_ptr_next      = (grant_idx == TAG_W'(NUM_CH-1)) ? '0 : grant_idx + 1'b1;
                    issue_state_next = SEND;
                end
            end
            SEND: begin
                if (filt_in_ack) begin
                    issue_state_next = ARB;
                end
            end
        endcase
    end

    always_comb begin
        ret_state_next = ret_state_reg;
        output_z_next  = output_z_reg;
        out_tag_next   = out_tag_reg;
        case (ret_state_reg)
            EMPTY: begin
                if (capture) begin
                    output_z_next  = filt_out_a;
                    out_tag_next   = fifo_dout;
                    ret_state_next = FULL;
                end
            end
            FULL: begin
                if (sink_ack) begin
                    ret_state_next = EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_state_reg <= ARB;
            ret_state_reg   <= EMPTY;
            rr_ptr_reg      <= '0;
            filt_in_z_reg   <= '0;
            output_z_reg    <= '0;
            out_tag_reg     <= '0;
        end else begin
            issue_state_reg <= issue_state_next;
            ret_state_reg   <= ret_state_next;
            rr_ptr_reg      <= rr_ptr_next;
            filt_in_z_reg   <= filt_in_z_next;
            output_z_reg    <= output_z_next;
            out_tag_reg     <= out_tag_next;
        end
    end

    chmux_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (issue_fire),
        .pop   (capture),
        .din   (grant_idx),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (inflight)
    );

endmodule

// File: tb/tb_ads1292_filter_chmux.sv
// Directed bench for ads1292_filter_chmux (4 channels, 4 tags) with an echo
// filter model (input ack one cycle after stb, result = input + 1).
module tb_ads1292_filter_chmux;

    localparam int DW = 32;
    localparam int NC = 4;
    localparam int TD = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NC*DW-1:0]  input_a = '0;
    logic [NC-1:0]     input_a_stb = '0;
    logic [NC-1:0]     input_a_ack;
    logic [DW-1:0]     filt_in_z;
    logic              filt_in_stb;
    logic              filt_in_ack;
    logic [DW-1:0]     filt_out_a;
    logic              filt_out_stb;
    logic              filt_out_ack;
    logic [DW-1:0]     output_z;
    logic [NC-1:0]     output_z_stb;
    logic [NC-1:0]     output_z_ack;
    logic [2:0]        inflight;

    // filter model and manual override
    logic          mdl_in_ack = 1'b0;
    logic          mdl_out_stb = 1'b0;
    logic [DW-1:0] mdl_out_a = '0;
    logic          mdl_hold = 1'b0;
    logic          mdl_in_block = 1'b0;
    logic          manual = 1'b0;
    logic          man_out_stb = 1'b0;
    logic [DW-1:0] man_out_a = '0;
    logic [NC-1:0] sink_en = '1;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] in_log[$];

    typedef struct {
        int            ch;
        logic [DW-1:0] d;
    } rec_t;
    rec_t outs[$];

    int n_checks = 0;
    int n_fail = 0;
    int sent[NC];

    always #5 clk = ~clk;

    assign filt_in_ack  = mdl_in_ack;
    assign filt_out_stb = manual ? man_out_stb : mdl_out_stb;
    assign filt_out_a   = manual ? man_out_a : mdl_out_a;
    assign output_z_ack = output_z_stb & sink_en;

    ads1292_filter_chmux #(
        .DATA_W    (DW),
        .NUM_CH    (NC),
        .TAG_DEPTH (TD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .filt_in_z    (filt_in_z),
        .filt_in_stb  (filt_in_stb),
        .filt_in_ack  (filt_in_ack),
        .filt_out_a   (filt_out_a),
        .filt_out_stb (filt_out_stb),
        .filt_out_ack (filt_out_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack),
        .inflight     (inflight)
    );

    // Echo filter model.
    always @(posedge clk) begin
        if (rst) begin
            mdl_in_ack  <= 1'b0;
            mdl_out_stb <= 1'b0;
            fq.delete();
        end else begin
            if (filt_in_stb && mdl_in_ack) begin
                $display("filter in  data=%h", filt_in_z);
                in_log.push_back(filt_in_z);
                fq.push_back(filt_in_z + 32'd1);
                mdl_in_ack <= 1'b0;
            end else if (filt_in_stb && !mdl_in_block) begin
                mdl_in_ack <= 1'b1;
            end
            if (mdl_out_stb && filt_out_ack && !manual) begin
                void'(fq.pop_front());
                mdl_out_stb <= 1'b0;
            end else if (!mdl_out_stb && fq.size() > 0 && !mdl_hold) begin
                mdl_out_stb <= 1'b1;
                mdl_out_a   <= fq[0];
            end
        end
    end

    // Sink collector.
    always @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NC; k++) begin
                if (output_z_stb[k] && output_z_ack[k]) begin
                    $display("output ch%0d data=%h", k, output_z);
                    outs.push_back('{k, output_z});
                end
            end
        end
    end

    task automatic reset_dut();
        rst = 1'b1;
        input_a_stb = '0;
        for (int k = 0; k < NC; k++) sent[k] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        outs.delete();
        in_log.delete();
    endtask

    // Per-channel sources: channel k sends k*0x100+n, dropping stb for one
    // cycle after every accept.
    task automatic stream_cycles(input int ncyc, input logic [NC-1:0] mask, input int limit);
        logic [NC-1:0] fired;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            fired = input_a_stb & input_a_ack;
            for (int k = 0; k < NC; k++) if (fired[k]) sent[k]++;
            @(posedge clk);
            #1;
            for (int k = 0; k < NC; k++) begin
                if (fired[k]) begin
                    input_a_stb[k] = 1'b0;
                end else if (mask[k] && !input_a_stb[k] && sent[k] < limit) begin
                    input_a[k*DW +: DW] = 32'(k*256 + sent[k]);
                    input_a_stb[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        input_a_stb = '1;
        input_a = {32'h4, 32'h3, 32'h2, 32'h1};
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (input_a_ack !== 4'b0) begin n_fail++; $display("FAIL reset_ack got=%b want=0000", input_a_ack); end
        end
        @(posedge clk);
        #1 rst = 1'b0;
        input_a_stb = '0;
        @(negedge clk);
        n_checks++;
        if (filt_in_stb !== 1'b0 || output_z_stb !== 4'b0 || input_a_ack !== 4'b0 || filt_out_ack !== 1'b0) begin
            n_fail++; $display("FAIL idle_stb got in_stb=%b out_stb=%b ack=%b fo_ack=%b want all 0", filt_in_stb, output_z_stb, input_a_ack, filt_out_ack);
        end
        n_checks++;
        if (inflight !== 3'd0) begin n_fail++; $display("FAIL idle_inflight got=%0d want=0", inflight); end
        n_checks++;
        if (output_z !== 32'h0 || filt_in_z !== 32'h0) begin n_fail++; $display("FAIL idle_data got out=%h in=%h want 0", output_z, filt_in_z); end
    endtask

    task automatic test_single();
        int t;
        reset_dut();
        sink_en = '1;
        input_a[1*DW +: DW] = 32'h10;
        input_a_stb[1] = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (input_a_ack == 4'b0 && t < 10);
        n_checks++;
        if (input_a_ack !== 4'b0010) begin n_fail++; $display("FAIL single_ack got=%b want=0010", input_a_ack); end
        @(posedge clk);
        #1 input_a_stb[1] = 1'b0;
        n_checks++;
        if (filt_in_stb !== 1'b1 || filt_in_z !== 32'h10) begin n_fail++; $display("FAIL single_issue got stb=%b z=%h want 1/00000010", filt_in_stb, filt_in_z); end
        t = 0;
        do begin @(negedge clk); t++; end while (output_z_stb == 4'b0 && t < 20);
        n_checks++;
        if (output_z_stb !== 4'b0010 || output_z !== 32'h11) begin n_fail++; $display("FAIL single_out got stb=%b z=%h want 0010/00000011", output_z_stb, output_z); end
        n_checks++;
        if (inflight !== 3'd0) begin n_fail++; $display("FAIL single_inflight got=%0d want=0", inflight); end
    endtask

    task automatic test_fairness();
        logic [DW-1:0] exp;
        reset_dut();
        sink_en = '1;
        stream_cycles(300, 4'hF, 8);
        n_checks++;
        if (in_log.size() != 32 || outs.size() != 32) begin n_fail++; $display("FAIL fair_count got in=%0d out=%0d want 32/32", in_log.size(), outs.size()); end
        for (int i = 0; i < 32; i++) begin
            exp = 32'((i % 4) * 256 + i / 4);
            n_checks++;
            if (i >= in_log.size() || in_log[i] !== exp) begin n_fail++; $display("FAIL fair_issue[%0d] want=%h", i, exp); end
            n_checks++;
            if (i >= outs.size() || outs[i].ch != i % 4 || outs[i].d !== exp + 32'd1) begin n_fail++; $display("FAIL fair_out[%0d] want ch%0d data=%h", i, i % 4, exp + 32'd1); end
        end
    endtask

    task automatic test_full_fifo();
        reset_dut();
        sink_en = '1;
        mdl_hold = 1'b1;
        stream_cycles(40, 4'b0001, 6);
        n_checks++;
        if (sent[0] != 4) begin n_fail++; $display("FAIL full_acks got=%0d want=4", sent[0]); end
        n_checks++;
        if (inflight !== 3'd4) begin n_fail++; $display("FAIL full_inflight got=%0d want=4", inflight); end
        mdl_hold = 1'b0;
        stream_cycles(80, 4'b0001, 6);
        n_checks++;
        if (sent[0] != 6 || outs.size() != 6) begin n_fail++; $display("FAIL full_drain got acks=%0d outs=%0d want 6/6", sent[0], outs.size()); end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (i >= outs.size() || outs[i].ch != 0 || outs[i].d !== 32'(i + 1)) begin n_fail++; $display("FAIL full_out[%0d] want ch0 data=%0d", i, i + 1); end
        end
        n_checks++;
        if (inflight !== 3'd0) begin n_fail++; $display("FAIL full_inflight_end got=%0d want=0", inflight); end
    endtask

    task automatic test_backpressure();
        reset_dut();
        sink_en = 4'b1110;
        stream_cycles(30, 4'b0001, 2);
        n_checks++;
        if (filt_out_stb !== 1'b1 || inflight !== 3'd1) begin n_fail++; $display("FAIL bp_setup got fo_stb=%b inflight=%0d want 1/1", filt_out_stb, inflight); end
        repeat (10) begin
            @(negedge clk);
            n_checks++;
            if (output_z_stb !== 4'b0001 || output_z !== 32'h1 || filt_out_ack !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold got stb=%b z=%h fo_ack=%b want 0001/00000001/0", output_z_stb, output_z, filt_out_ack);
            end
        end
        sink_en = '1;
        stream_cycles(20, 4'b0001, 2);
        n_checks++;
        if (outs.size() != 2 || outs[0].d !== 32'h1 || outs[1].d !== 32'h2 || outs[0].ch != 0 || outs[1].ch != 0) begin
            n_fail++; $display("FAIL bp_release got count=%0d want ch0 1,2", outs.size());
        end
        n_checks++;
        if (inflight !== 3'd0) begin n_fail++; $display("FAIL bp_inflight got=%0d want=0", inflight); end
    endtask

    task automatic test_mid_reset();
        reset_dut();
        sink_en = '1;
        mdl_hold = 1'b1;
        stream_cycles(20, 4'b0001, 2);
        mdl_in_block = 1'b1;
        stream_cycles(8, 4'b0001, 3);
        n_checks++;
        if (inflight !== 3'd3 || filt_in_stb !== 1'b1) begin n_fail++; $display("FAIL mid_setup got inflight=%0d stb=%b want 3/1", inflight, filt_in_stb); end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        mdl_in_block = 1'b0;
        mdl_hold = 1'b0;
        @(negedge clk);
        n_checks++;
        if (inflight !== 3'd0 || filt_in_stb !== 1'b0) begin n_fail++; $display("FAIL mid_after got inflight=%0d stb=%b want 0/0", inflight, filt_in_stb); end
        manual = 1'b1;
        man_out_a = 32'hDEAD;
        man_out_stb = 1'b1;
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if (filt_out_ack !== 1'b0 || output_z_stb !== 4'b0) begin n_fail++; $display("FAIL mid_spurious got fo_ack=%b stb=%b want 0/0000", filt_out_ack, output_z_stb); end
        end
        man_out_stb = 1'b0;
        manual = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_full_fifo();
        test_backpressure();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
